// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between the I- and D-cache ports of CPUS cores.
// Round-robin across cores, D-write > D-read > I-read within a core. A registered
// grant FSM holds each transaction until the RAM completes, errors or the requester
// withdraws. Wait strobes and RAM enables are combinational on the granted request.
module memory_arbiter #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    input  logic [1:0]               ramstate,
    input  logic [WORD_W-1:0]        ramload,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [$clog2(CPUS):0]    gnt_cpu,
    output logic                     busy,
    output logic [7:0]               err_cnt
);

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int GW = $clog2(CPUS) + 1;

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    typedef enum logic {IDLE, GRANT} state_t;
    typedef enum logic [1:0] {K_WRITE, K_DREAD, K_IREAD} kind_t;

    state_t          state;
    kind_t           kind_q;
    logic [IW-1:0]   cpu_q;
    logic [IW-1:0]   rr_ptr;

    logic            found;
    logic [IW-1:0]   win;
    kind_t           win_kind;
    logic [ADDR_W-1:0] win_addr;
    logic [WORD_W-1:0] win_store;

    logic            live;
    logic            active;
    logic            ack;

    // Pick the first requesting core starting at rr_ptr, and its highest-priority channel.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        found     = 1'b0;
        win       = '0;
        win_kind  = K_IREAD;
        win_addr  = '0;
        win_store = '0;
        for (int i = 0; i < CPUS; i++) begin
            logic [IW-1:0] idx;
            idx = IW'((int'(rr_ptr) + i) % CPUS);
            if (!found && (iREN[idx] || dREN[idx] || dWEN[idx])) begin
                found     = 1'b1;
                win       = idx;
                win_store = dstore[idx*WORD_W +: WORD_W];
                if (dWEN[idx]) begin
                    win_kind = K_WRITE;
                    win_addr = daddr[idx*ADDR_W +: ADDR_W];
                end else if (dREN[idx]) begin
                    win_kind = K_DREAD;
                    win_addr = daddr[idx*ADDR_W +: ADDR_W];
                end else begin
                    win_kind = K_IREAD;
                    win_addr = iaddr[idx*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    // Drive RAM enables and the single completing wait strobe from the live granted request.
    always_comb begin
        case (kind_q)
            K_WRITE: live = dWEN[cpu_q];
            K_DREAD: live = dREN[cpu_q];
            default: live = iREN[cpu_q];
        endcase
        // Reset forces enables and acks off in the same cycle it is seen.
        active = (state == GRANT) && !RST && live;
        ack    = active && (ramstate == RAM_ACCESS);
        ramWEN = active && (kind_q == K_WRITE);
        ramREN = active && (kind_q != K_WRITE);
        iwait  = '1;
        dwait  = '1;
        if (ack) begin
            if (kind_q == K_IREAD) iwait[cpu_q] = 1'b0;
            else                   dwait[cpu_q] = 1'b0;
        end
    end

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    // Grant FSM: latch the winner in IDLE, hold it in GRANT until ack, error or withdrawal.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RST) begin
            state    <= IDLE;
            kind_q   <= K_IREAD;
            cpu_q    <= '0;
            rr_ptr   <= '0;
            ramaddr  <= '0;
            ramstore <= '0;
            gnt_cpu  <= '0;
            busy     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        cpu_q    <= win;
                        kind_q   <= win_kind;
                        ramaddr  <= win_addr;
                        ramstore <= win_store;
                        gnt_cpu  <= GW'(win);
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!live) begin
                        // Requester withdrew: abort without moving the round-robin pointer.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (ramstate == RAM_ACCESS) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= (cpu_q == IW'(CPUS - 1)) ? '0 : cpu_q + IW'(1);
                    end else if (ramstate == RAM_ERROR) begin
                        // Pointer stays put so the same requester is retried first.
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter (CPUS=2): table-driven single transactions,
// then hand-written sequences for round-robin, priority, stalls, errors, reset and aborts.
// A scoreboard queue holds expected acks; a negedge monitor pops and compares them.
module tb_memory_arbiter;

    localparam int CPUS = 2;
    localparam int AW   = 32;
    localparam int WW   = 32;

    localparam logic [1:0] FREE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] ACC  = 2'b10;
    localparam logic [1:0] ERR  = 2'b11;

    localparam int KW = 0;
    localparam int KD = 1;
    localparam int KI = 2;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [CPUS-1:0]       iREN, dREN, dWEN;
    logic [CPUS*AW-1:0]    iaddr, daddr;
    logic [CPUS*WW-1:0]    dstore;
    logic [CPUS-1:0]       iwait, dwait;
    logic [CPUS*WW-1:0]    iload, dload;
    logic [1:0]            ramstate;
    logic [WW-1:0]         ramload;
    logic [AW-1:0]         ramaddr;
    logic [WW-1:0]         ramstore;
    logic                  ramREN, ramWEN;
    logic [$clog2(CPUS):0] gnt_cpu;
    logic                  busy;
    logic [7:0]            err_cnt;

    memory_arbiter #(.CPUS(CPUS), .ADDR_W(AW), .WORD_W(WW)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramstate(ramstate), .ramload(ramload),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .gnt_cpu(gnt_cpu), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cpu;
        int          kind;
        logic [31:0] addr;
        logic [31:0] store;
    } exp_t;

    typedef struct {
        int          cpu;
        bit          ir, dr, dw;
        logic [31:0] ia, da, ds;
        int          kind;
        logic [31:0] addr;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ack_cnt = 0;
    int   ack_cyc[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_in();
        iREN = '0;
        dREN = '0;
        dWEN = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_in();
        ramstate = FREE;
        tick(2);
        RST = 1'b0;
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: any low wait is an ack; compare it against the head of the scoreboard.
    always @(negedge CLK) begin : mon
        int   lows;
        int   acpu;
        int   akind;
        exp_t e;
        if (!RST) begin
            lows = $countones(~{iwait, dwait});
            if (lows != 0) begin
                check("one_wait_low", lows, 1);
                acpu  = -1;
                akind = -1;
                for (int i = 0; i < CPUS; i++) begin
                    if (!iwait[i]) begin acpu = i; akind = KI; end
                    if (!dwait[i]) begin acpu = i; akind = ramWEN ? KW : KD; end
                end
                ack_cnt++;
                ack_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: cpu %0d acked with nothing expected", acpu);
                end else begin
                    e = sb.pop_front();
                    check("ack_cpu", acpu, e.cpu);
                    check("gnt_cpu", gnt_cpu, e.cpu);
                    check("ack_kind", akind, e.kind);
                    check("ramaddr", ramaddr, e.addr);
                    if (e.kind == KW) begin
                        check("ramWEN", ramWEN, 1);
                        check("ramstore", ramstore, e.store);
                    end else begin
                        check("ramREN", ramREN, 1);
                        check("load", (e.kind == KI) ? iload[e.cpu*WW +: WW] : dload[e.cpu*WW +: WW], ramload);
                    end
                end
            end
        end
    end

    initial begin
        vec_t vt[7];
        int   base;
        int   c;

        RST = 1'b1;
        clear_in();
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = '0;

        vt[0] = '{0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h1000, 32'h0,        KI, 32'h40};
        vt[1] = '{1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h1004, 32'h0,        KI, 32'h44};
        vt[2] = '{0, 1'b0, 1'b1, 1'b0, 32'h48, 32'h2000, 32'h0,        KD, 32'h2000};
        vt[3] = '{1, 1'b0, 1'b0, 1'b1, 32'h4C, 32'h2004, 32'hCAFE0003, KW, 32'h2004};
        vt[4] = '{0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h3000, 32'h0,        KD, 32'h3000};
        vt[5] = '{1, 1'b0, 1'b1, 1'b1, 32'h54, 32'h3004, 32'h12345678, KW, 32'h3004};
        vt[6] = '{0, 1'b1, 1'b1, 1'b1, 32'h58, 32'h3008, 32'h0BADF00D, KW, 32'h3008};

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_gnt", gnt_cpu, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ren", ramREN, 0);
        check("rst_wen", ramWEN, 0);
        check("rst_iwait", iwait, 2'b11);
        check("rst_dwait", dwait, 2'b11);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ramstore", ramstore, 0);

        // Single transactions from the table; ack must land exactly one cycle after grant
        ramstate = ACC;
        for (int i = 0; i < 7; i++) begin
            base    = ack_cnt;
            ramload = 32'hA5000000 + i;
            c       = vt[i].cpu;
            iaddr[c*AW +: AW]  = vt[i].ia;
            daddr[c*AW +: AW]  = vt[i].da;
            dstore[c*WW +: WW] = vt[i].ds;
            iREN[c] = vt[i].ir;
            dREN[c] = vt[i].dr;
            dWEN[c] = vt[i].dw;
            sb.push_back('{c, vt[i].kind, vt[i].addr, vt[i].ds});
            tick();
            check("vec_no_early_ack", ack_cnt - base, 0);
            tick();
            clear_in();
            check("vec_ack_count", ack_cnt - base, 1);
        end

        // Round-robin: both cores hold dREN, RAM always ready
        do_reset();
        ramstate = ACC;
        ramload  = 32'h0000BEEF;
        daddr[0*AW +: AW] = 32'h100;
        daddr[1*AW +: AW] = 32'h200;
        dREN = 2'b11;
        sb.push_back('{0, KD, 32'h100, 32'h0});
        sb.push_back('{1, KD, 32'h200, 32'h0});
        sb.push_back('{0, KD, 32'h100, 32'h0});
        sb.push_back('{1, KD, 32'h200, 32'h0});
        ack_cyc.delete();
        base = ack_cnt;
        tick(8);
        clear_in();
        check("rr_ack_count", ack_cnt - base, 4);
        if (ack_cyc.size() == 4)
            for (int i = 0; i < 3; i++) check("rr_spacing", ack_cyc[i+1] - ack_cyc[i], 2);

        // Write beats I-read on the same core; I-read follows
        do_reset();
        ramstate = ACC;
        ramload  = 32'h11112222;
        daddr[0*AW +: AW]  = 32'h300;
        dstore[0*WW +: WW] = 32'hDEADBEEF;
        iaddr[0*AW +: AW]  = 32'h80;
        dWEN[0] = 1'b1;
        iREN[0] = 1'b1;
        sb.push_back('{0, KW, 32'h300, 32'hDEADBEEF});
        sb.push_back('{0, KI, 32'h80, 32'h0});
        base = ack_cnt;
        tick(2);
        dWEN[0] = 1'b0;
        tick(2);
        clear_in();
        check("prio_ack_count", ack_cnt - base, 2);

        // RAM stalls 5 cycles; a competing request must not preempt
        do_reset();
        ramstate = BUSY;
        daddr[1*AW +: AW] = 32'h400;
        dREN[1] = 1'b1;
        sb.push_back('{1, KD, 32'h400, 32'h0});
        base = ack_cnt;
        tick();
        iaddr[0*AW +: AW] = 32'h90;
        iREN[0] = 1'b1;
        sb.push_back('{0, KI, 32'h90, 32'h0});
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("stall_dwait_high", dwait[1], 1);
            check("stall_gnt", gnt_cpu, 1);
            @(posedge CLK);
            #1;
        end
        ramstate = ACC;
        @(negedge CLK);
        check("stall_ack_6th", dwait[1], 0);
        @(posedge CLK);
        #1;
        dREN[1] = 1'b0;
        tick(2);
        clear_in();
        check("stall_ack_count", ack_cnt - base, 2);

        // ERROR: no ack, counter saturates, same core regranted ahead of the other
        do_reset();
        ramstate = ERR;
        daddr[0*AW +: AW] = 32'h500;
        iaddr[1*AW +: AW] = 32'h600;
        dREN[0] = 1'b1;
        iREN[1] = 1'b1;
        base = ack_cnt;
        tick(2);
        check("err_first", err_cnt, 1);
        check("err_idle", busy, 0);
        tick();
        check("err_regrant_busy", busy, 1);
        check("err_regrant_cpu", gnt_cpu, 0);
        tick(505);
        check("err_254", err_cnt, 254);
        tick(2);
        check("err_255", err_cnt, 255);
        tick(90);
        check("err_sat_300", err_cnt, 255);
        check("err_no_ack", ack_cnt - base, 0);
        ramstate = ACC;
        ramload  = 32'h33334444;
        sb.push_back('{0, KD, 32'h500, 32'h0});
        sb.push_back('{1, KI, 32'h600, 32'h0});
        tick(2);
        dREN[0] = 1'b0;
        tick(2);
        clear_in();
        check("err_recover_count", ack_cnt - base, 2);

        // Reset mid-GRANT: enables drop at once, rr_ptr returns to 0
        do_reset();
        ramstate = ACC;
        daddr[0*AW +: AW] = 32'h700;
        dREN[0] = 1'b1;
        sb.push_back('{0, KD, 32'h700, 32'h0});
        tick(2);
        dREN[0] = 1'b0;
        ramstate = BUSY;
        daddr[1*AW +: AW]  = 32'h800;
        dstore[1*WW +: WW] = 32'h000055AA;
        dWEN[1] = 1'b1;
        tick();
        @(negedge CLK);
        check("midrst_wen_before", ramWEN, 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_wen_at_once", ramWEN, 0);
        @(posedge CLK);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_wen", ramWEN, 0);
        check("midrst_ren", ramREN, 0);
        check("midrst_iwait", iwait, 2'b11);
        check("midrst_dwait", dwait, 2'b11);
        check("midrst_gnt", gnt_cpu, 0);
        RST = 1'b0;
        dWEN[1] = 1'b0;
        daddr[0*AW +: AW] = 32'h900;
        dREN = 2'b11;
        ramstate = ACC;
        sb.push_back('{0, KD, 32'h900, 32'h0});
        sb.push_back('{1, KD, 32'h800, 32'h0});
        base = ack_cnt;
        tick(4);
        clear_in();
        check("midrst_rr0_count", ack_cnt - base, 2);

        // Request withdrawn mid-GRANT: abort, no ack, address held
        ramstate = BUSY;
        iaddr[1*AW +: AW] = 32'hA00;
        iREN[1] = 1'b1;
        base = ack_cnt;
        tick();
        @(negedge CLK);
        check("drop_ren_before", ramREN, 1);
        @(posedge CLK);
        #1;
        iREN[1] = 1'b0;
        ramstate = ACC;
        @(negedge CLK);
        check("drop_ren_at_once", ramREN, 0);
        check("drop_iwait", iwait, 2'b11);
        @(posedge CLK);
        #1;
        check("drop_idle", busy, 0);
        tick();
        check("drop_no_ack", ack_cnt - base, 0);
        check("drop_addr_held", ramaddr, 32'hA00);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
